// File: rtl/seq_add_sub_n.sv
// Sliced ripple add/sub: SLICE bits per clock, LS slice first, carry held in a register.
// DONE pulses N+1 cycles after an accepted START; START is ignored while BUSY.
module seq_add_sub_n #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sna,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_y,
  output logic             o_co,
  output logic             o_ov,
  output logic             o_zf
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_c;
  logic [IDXW-1:0]  r_idx;

  int               w_base;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_sum;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_final;

  always_comb begin
    w_base  = int'(r_idx) * SLICE;
    w_a_sl  = r_a[w_base +: SLICE];
    w_b_sl  = r_b[w_base +: SLICE];
    w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_c};
    // Carry into the slice's top bit; only meaningful on the last slice (the word MSB).
    w_cmsb  = w_sum[SLICE-1] ^ w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1];
    w_last  = (r_idx == IDXW'(N - 1));
    w_final = r_work;
    w_final[w_base +: SLICE] = w_sum[SLICE-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_y     <= '0;
      o_co    <= 1'b0;
      o_ov    <= 1'b0;
      o_zf    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b ^ {WIDTH{i_sna}};
            r_c     <= i_sna;
            r_idx   <= '0;
            r_work  <= '0;
            o_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work[w_base +: SLICE] <= w_sum[SLICE-1:0];
          r_c   <= w_sum[SLICE];
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            o_y     <= w_final;
            o_co    <= w_sum[SLICE];
            o_ov    <= w_cmsb ^ w_sum[SLICE];
            o_zf    <= (w_final == '0);
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
